// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;
    localparam int WORD_SIZE = 32;
    localparam logic [WORD_SIZE-1:0] RESET_PC = 32'h0000_1000;
    localparam logic [WORD_SIZE-1:0] PC_INCR  = 32'd4;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry instruction/PC register that keeps a fetched word alive across a decode stall.
module fetch_hold_buffer
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] instr_in,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic [WORD_SIZE-1:0] hold_instr,
    output logic [WORD_SIZE-1:0] hold_pc
);
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (load) begin
            hold_instr <= instr_in;
            hold_pc    <= pc_in;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, i-cache request handshake, stall hold and jump redirect.
// Handshake: icache_req/icache_addr stay asserted and stable until icache_ready is seen for that address.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 jump_taken,
    input  logic [WORD_SIZE-1:0] jump_target,
    output logic                 icache_req,
    output logic [WORD_SIZE-1:0] icache_addr,
    input  logic                 icache_ready,
    input  logic [WORD_SIZE-1:0] icache_data,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] pc_out
);
    fetch_state_e         state, next_state;
    logic [WORD_SIZE-1:0] pc, next_pc;
    logic [WORD_SIZE-1:0] redirect_pc, next_redirect_pc;
    logic [WORD_SIZE-1:0] hold_instr, hold_pc;
    logic [WORD_SIZE-1:0] target;
    logic                 hold_load, hold_clear;

    assign target = word_align(jump_target);

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .clear      (hold_clear),
        .instr_in   (icache_data),
        .pc_in      (pc),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            redirect_pc <= '0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            redirect_pc <= next_redirect_pc;
        end
    end

    always_comb begin
        next_state       = state;
        next_pc          = pc;
        next_redirect_pc = redirect_pc;
        hold_load        = 1'b0;
        hold_clear       = 1'b0;
        icache_req       = 1'b0;
        icache_addr      = pc;
        instruction      = '0;
        pc_out           = '0;
        valid            = 1'b0;

        if (rst) begin
            unique case (state)
                FETCH_RUN: begin
                    icache_req = 1'b1;
                    if (jump_taken) begin
                        // A miss in flight must still be drained before the new path starts.
                        if (icache_ready) begin
                            next_pc = target;
                        end else begin
                            next_redirect_pc = target;
                            next_state       = FETCH_DRAIN;
                        end
                    end else if (icache_ready) begin
                        instruction = icache_data;
                        pc_out      = pc;
                        valid       = 1'b1;
                        next_pc     = pc + PC_INCR;
                        if (stall_in) begin
                            hold_load  = 1'b1;
                            next_state = FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (jump_taken) begin
                        hold_clear = 1'b1;
                        next_pc    = target;
                        next_state = FETCH_RUN;
                    end else begin
                        instruction = hold_instr;
                        pc_out      = hold_pc;
                        valid       = 1'b1;
                        if (!stall_in) begin
                            next_state = FETCH_RUN;
                        end
                    end
                end
                FETCH_DRAIN: begin
                    icache_req = 1'b1;
                    if (jump_taken) begin
                        next_redirect_pc = target;
                    end
                    if (icache_ready) begin
                        next_pc    = jump_taken ? target : redirect_pc;
                        next_state = FETCH_RUN;
                    end
                end
                default: begin
                    next_state = FETCH_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the i-cache model returns addr ^ 32'hDEAD_0000 as data.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic [31:0] instruction;
    logic        valid;
    logic [31:0] pc_out;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_ready (icache_ready),
        .icache_data  (icache_data),
        .instruction  (instruction),
        .valid        (valid),
        .pc_out       (pc_out)
    );

    assign icache_data = icache_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic s, input logic j,
                         input logic [31:0] t, input logic rdy);
        @(negedge clk);
        rst          = r;
        stall_in     = s;
        jump_taken   = j;
        jump_target  = t;
        icache_ready = rdy;
        #1;
    endtask

    // Checks request/valid, plus address when requesting and instruction/pc when valid.
    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc);
        check({tag, ".req"}, {31'd0, icache_req}, {31'd0, req});
        if (req) check({tag, ".addr"}, icache_addr, addr);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        if (v) begin
            check({tag, ".pc"}, pc_out, pc);
            check({tag, ".instr"}, instruction, pc ^ 32'hDEAD_0000);
        end
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check({tag, ".rst_req"}, {31'd0, icache_req}, 32'd0);
        check({tag, ".rst_valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".rst_instr"}, instruction, 32'd0);
        check({tag, ".rst_pc"}, pc_out, 32'd0);
    endtask

    initial begin
        rst = 1'b0; stall_in = 1'b0; jump_taken = 1'b0;
        jump_target = '0; icache_ready = 1'b0;

        // Straight-line hits
        do_reset("seq");
        drive(1, 0, 0, 0, 1); expect_out("seq0", 1, 32'h1000, 1, 32'h1000);
        drive(1, 0, 0, 0, 1); expect_out("seq1", 1, 32'h1004, 1, 32'h1004);
        drive(1, 0, 0, 0, 1); expect_out("seq2", 1, 32'h1008, 1, 32'h1008);

        // Three-cycle miss at 0x1008, stall during the miss has no effect
        do_reset("miss");
        drive(1, 0, 0, 0, 1); expect_out("miss_h0", 1, 32'h1000, 1, 32'h1000);
        drive(1, 0, 0, 0, 1); expect_out("miss_h1", 1, 32'h1004, 1, 32'h1004);
        drive(1, 0, 0, 0, 0); expect_out("miss_m0", 1, 32'h1008, 0, 0);
        drive(1, 1, 0, 0, 0); expect_out("miss_m1", 1, 32'h1008, 0, 0);
        drive(1, 0, 0, 0, 0); expect_out("miss_m2", 1, 32'h1008, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("miss_resp", 1, 32'h1008, 1, 32'h1008);
        drive(1, 0, 0, 0, 1); expect_out("miss_next", 1, 32'h100C, 1, 32'h100C);

        // Two-cycle stall on the hit at 0x1004
        do_reset("stall");
        drive(1, 0, 0, 0, 1); expect_out("stall_h0", 1, 32'h1000, 1, 32'h1000);
        drive(1, 1, 0, 0, 1); expect_out("stall_in0", 1, 32'h1004, 1, 32'h1004);
        drive(1, 1, 0, 0, 1); expect_out("stall_hold1", 0, 0, 1, 32'h1004);
        drive(1, 0, 0, 0, 1); expect_out("stall_hold2", 0, 0, 1, 32'h1004);
        drive(1, 0, 0, 0, 1); expect_out("stall_next", 1, 32'h1008, 1, 32'h1008);

        // Jump on a hit, misaligned target is forced to word alignment
        do_reset("jmp");
        drive(1, 0, 0, 0, 1); expect_out("jmp_h0", 1, 32'h1000, 1, 32'h1000);
        drive(1, 0, 1, 32'h2002, 1); expect_out("jmp_cyc", 1, 32'h1004, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("jmp_tgt", 1, 32'h2000, 1, 32'h2000);
        drive(1, 0, 0, 0, 1); expect_out("jmp_tgt4", 1, 32'h2004, 1, 32'h2004);

        // Two jumps during a miss: response discarded, last target wins
        do_reset("drain");
        drive(1, 0, 0, 0, 1); expect_out("drain_h0", 1, 32'h1000, 1, 32'h1000);
        drive(1, 0, 0, 0, 1); expect_out("drain_h1", 1, 32'h1004, 1, 32'h1004);
        drive(1, 0, 1, 32'h3000, 0); expect_out("drain_j1", 1, 32'h1008, 0, 0);
        drive(1, 0, 1, 32'h4000, 0); expect_out("drain_j2", 1, 32'h1008, 0, 0);
        drive(1, 0, 0, 0, 0); expect_out("drain_wait", 1, 32'h1008, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("drain_resp", 1, 32'h1008, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("drain_tgt", 1, 32'h4000, 1, 32'h4000);

        // Jump while stalled in HOLD: hold dropped, target fetched next
        do_reset("hj");
        drive(1, 1, 0, 0, 1); expect_out("hj_cap", 1, 32'h1000, 1, 32'h1000);
        drive(1, 1, 1, 32'h5000, 1); expect_out("hj_jump", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("hj_tgt", 1, 32'h5000, 1, 32'h5000);

        // Reset during a miss restarts at the reset PC
        do_reset("rm");
        drive(1, 0, 0, 0, 0); expect_out("rm_miss", 1, 32'h1000, 0, 0);
        drive(1, 0, 0, 0, 0); expect_out("rm_miss2", 1, 32'h1000, 0, 0);
        do_reset("rm_mid");
        drive(1, 0, 0, 0, 1); expect_out("rm_after", 1, 32'h1000, 1, 32'h1000);

        // PC wrap at the top of the address space
        drive(1, 0, 1, 32'hFFFF_FFFF, 1); expect_out("wrap_jump", 1, 32'h1004, 0, 0);
        drive(1, 0, 0, 0, 1); expect_out("wrap_top", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 1); expect_out("wrap_zero", 1, 32'h0000_0000, 1, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
